// File: rtl/barrel_shifter_left_pipe.sv
// barrel_shifter_left_pipe: SW-stage registered left shifter with valid/ready flow control and shifted-out detect.
// Rotate-left support is built only when SHL_ROTATE_EN is defined; otherwise in_rot is ignored.
module barrel_shifter_left_pipe #(
  parameter  int WIDTH = 32,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost
);

  logic             r_valid [SW];
  logic [WIDTH-1:0] r_data  [SW];
  logic [SW-1:0]    r_shamt [SW];
  logic             r_rot   [SW];
  logic             r_lost  [SW];

  logic             w_up_valid [SW];
  logic [WIDTH-1:0] w_up_data  [SW];
  logic [SW-1:0]    w_up_shamt [SW];
  logic             w_up_rot   [SW];
  logic             w_up_lost  [SW];
  logic [WIDTH-1:0] w_nxt_data [SW];
  logic             w_nxt_lost [SW];
  logic [SW:0]      w_ld;
  logic             w_rot_in;

`ifdef SHL_ROTATE_EN
  assign w_rot_in = in_rot;
`else
  logic w_unused_rot;
  assign w_rot_in     = 1'b0;
  assign w_unused_rot = in_rot;
`endif

  // A stage loads whenever it is empty or its successor is loading, so bubbles collapse under stall.
  always_comb begin
    w_ld     = '0;
    w_ld[SW] = out_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      w_ld[k] = !r_valid[k] || w_ld[k+1];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int STEP = 1 << k;
    logic [WIDTH-1:0] w_shl;
    logic             w_spill;

    if (k == 0) begin : g_head
      assign w_up_valid[k] = in_valid;
      assign w_up_data[k]  = in_data;
      assign w_up_shamt[k] = in_shamt;
      assign w_up_rot[k]   = w_rot_in;
      assign w_up_lost[k]  = 1'b0;
    end else begin : g_link
      assign w_up_valid[k] = r_valid[k-1];
      assign w_up_data[k]  = r_data[k-1];
      assign w_up_shamt[k] = r_shamt[k-1];
      assign w_up_rot[k]   = r_rot[k-1];
      assign w_up_lost[k]  = r_lost[k-1];
    end

    assign w_shl   = w_up_data[k] << STEP;
    assign w_spill = |w_up_data[k][WIDTH-1 -: STEP];

`ifdef SHL_ROTATE_EN
    assign w_nxt_data[k] = !w_up_shamt[k][k] ? w_up_data[k] :
                           w_up_rot[k] ? {w_up_data[k][WIDTH-STEP-1:0], w_up_data[k][WIDTH-1 -: STEP]} :
                           w_shl;
`else
    assign w_nxt_data[k] = w_up_shamt[k][k] ? w_shl : w_up_data[k];
`endif

    // Rotated bits re-enter at the LSB end, so they never count as lost.
    assign w_nxt_lost[k] = w_up_lost[k] | (w_up_shamt[k][k] & !w_up_rot[k] & w_spill);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SW; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_shamt[k] <= '0;
        r_rot[k]   <= 1'b0;
        r_lost[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SW; k++) begin
        if (w_ld[k]) begin
          r_valid[k] <= w_up_valid[k];
          r_data[k]  <= w_nxt_data[k];
          r_shamt[k] <= w_up_shamt[k];
          r_rot[k]   <= w_up_rot[k];
          r_lost[k]  <= w_nxt_lost[k];
        end
      end
    end
  end

  assign in_ready  = w_ld[0];
  assign out_valid = r_valid[SW-1];
  assign out_data  = r_data[SW-1];
  assign out_lost  = r_lost[SW-1];

endmodule
